// File: rtl/divisor_ctrl_if.sv
// Button, load/ack handshake and status signals between the panel controller and its peers.
// master = the controller (divisor_ctrl); slave = buttons/divisor side.
interface divisor_ctrl_if;
  logic       up;
  logic       down;
  logic       ok;
  logic       cfg_ack;
  logic [3:0] sel;
  logic       cfg_load;
  logic [3:0] leds;
  logic       busy;
  logic       err;

  modport master (
    input  up, down, ok, cfg_ack,
    output sel, cfg_load, leds, busy, err
  );

  modport slave (
    output up, down, ok, cfg_ack,
    input  sel, cfg_load, leds, busy, err
  );
endinterface

// File: rtl/divisor_ctrl.sv
// Front-panel controller: edits a divisor selection with up/down/ok and commits it via load/ack.
// Optional hold-to-repeat stepping in EDIT is enabled by defining DIVCTL_AUTOREPEAT_EN.
module divisor_ctrl #(
  parameter int MIN_SEL      = 1,
  parameter int MAX_SEL      = 15,
  parameter int ACK_TIMEOUT  = 15,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 4
) (
  input  logic           clk,
  input  logic           rst,
  divisor_ctrl_if.master bus
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  if (MAX_SEL > 15 || MAX_SEL <= MIN_SEL || MIN_SEL < 0 || ACK_TIMEOUT < 1 ||
      REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DELAY) begin : g_bad_cfg
    $error("divisor_ctrl: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EDIT = 2'd1,
    S_LOAD = 2'd2
  } state_t;

  state_t        r_state, w_state_next;
  logic [3:0]    r_cand, w_cand_next;
  logic [3:0]    r_comm, w_comm_next;
  logic          r_err, w_err_next;
  logic [TW-1:0] r_tmo_cnt, w_tmo_next;

  logic [2:0] w_btn;
  logic [2:0] r_rel;
  logic [2:0] w_press;
  logic       w_step_up, w_step_dn, w_ok;
  logic       w_rpt_step;

  assign w_btn = {bus.ok, bus.down, bus.up};

  // r_rel marks "was released last cycle"; clearing it in reset means a
  // button held through reset must be released before it can press again.
  for (genvar gi = 0; gi < 3; gi++) begin : g_edge
    always_ff @(posedge clk) begin
      if (rst) r_rel[gi] <= 1'b0;
      else     r_rel[gi] <= ~w_btn[gi];
    end
    assign w_press[gi] = w_btn[gi] & r_rel[gi];
  end

  assign w_ok      = w_press[2];
  assign w_step_up = w_press[0] & ~w_press[1] & ~w_press[2];
  assign w_step_dn = w_press[1] & ~w_press[0] & ~w_press[2];

  function automatic logic [3:0] f_inc(input logic [3:0] v);
    return (v == 4'(MAX_SEL)) ? 4'(MIN_SEL) : v + 4'd1;
  endfunction

  function automatic logic [3:0] f_dec(input logic [3:0] v);
    return (v == 4'(MIN_SEL)) ? 4'(MAX_SEL) : v - 4'd1;
  endfunction

`ifdef DIVCTL_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + 1);

  logic [RW-1:0] r_rpt_cnt, w_rpt_cnt_next;
  logic          w_hold;

  // Counting only while exactly one direction is held without any new press.
  assign w_hold = (r_state == S_EDIT) & (bus.up ^ bus.down) & ~bus.ok & ~(|w_press);

  always_comb begin
    w_rpt_step     = 1'b0;
    w_rpt_cnt_next = '0;
    if (w_hold) begin
      if (r_rpt_cnt == RW'(REPEAT_DELAY - 1)) begin
        w_rpt_step     = 1'b1;
        w_rpt_cnt_next = RW'(REPEAT_DELAY - REPEAT_RATE);
      end else begin
        w_rpt_cnt_next = r_rpt_cnt + RW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_rpt_cnt <= '0;
    else     r_rpt_cnt <= w_rpt_cnt_next;
  end
`else
  assign w_rpt_step = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_cand_next  = r_cand;
    w_comm_next  = r_comm;
    w_err_next   = r_err;
    w_tmo_next   = r_tmo_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_ok) begin
          w_cand_next  = r_comm;
          w_tmo_next   = '0;
          w_state_next = S_LOAD;
        end else if (w_step_up) begin
          w_cand_next  = f_inc(r_comm);
          w_state_next = S_EDIT;
        end else if (w_step_dn) begin
          w_cand_next  = f_dec(r_comm);
          w_state_next = S_EDIT;
        end
      end
      S_EDIT: begin
        if (w_ok) begin
          w_tmo_next   = '0;
          w_state_next = S_LOAD;
        end else if (w_step_up || (w_rpt_step && bus.up)) begin
          w_cand_next = f_inc(r_cand);
        end else if (w_step_dn || (w_rpt_step && bus.down)) begin
          w_cand_next = f_dec(r_cand);
        end
      end
      S_LOAD: begin
        // Ack in the final allowed cycle still wins over the abort.
        if (bus.cfg_ack) begin
          w_comm_next  = r_cand;
          w_err_next   = 1'b0;
          w_state_next = S_IDLE;
        end else if (r_tmo_cnt == TW'(ACK_TIMEOUT - 1)) begin
          w_err_next   = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_tmo_next = r_tmo_cnt + TW'(1);
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cand    <= 4'(MIN_SEL);
      r_comm    <= 4'(MIN_SEL);
      r_err     <= 1'b0;
      r_tmo_cnt <= '0;
    end else begin
      r_cand    <= w_cand_next;
      r_comm    <= w_comm_next;
      r_err     <= w_err_next;
      r_tmo_cnt <= w_tmo_next;
    end
  end

  assign bus.sel      = r_cand;
  assign bus.cfg_load = (r_state == S_LOAD);
  assign bus.busy     = (r_state == S_LOAD);
  assign bus.leds     = (r_state == S_EDIT) ? r_cand : r_comm;
  assign bus.err      = r_err;

endmodule

// File: doc/divisor_ctrl.md
# divisor_ctrl

Front-panel controller for the 4-bit divisor block. It turns the raw up/down/ok buttons into a validated divisor selection and owns the committed setting. It pushes each new setting to the divisor with a load/ack handshake and drives the 4 status LEDs. It sits between the synchronized button inputs and the divisor's configuration port.

## Interface

- `MIN_SEL`, 1: lowest legal selection; also the reset value of the committed setting.
- `MAX_SEL`, 15: highest legal selection; must be ≤ 15 and > `MIN_SEL`.
- `ACK_TIMEOUT`, 15: cycles `cfg_load` may stay high without `cfg_ack` before the load is aborted.
- `REPEAT_DELAY`, 8: hold cycles before auto-repeat starts. Used only with `DIVCTL_AUTOREPEAT_EN`.
- `REPEAT_RATE`, 4: cycles between auto-repeat steps. Used only with `DIVCTL_AUTOREPEAT_EN`.

Ports:

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `up`  in  1  button level, already synchronized to `clk`.
- `down`  in  1  button level, already synchronized.
- `ok`  in  1  button level, already synchronized.
- `cfg_ack`  in  1  divisor accepted `sel`; sampled only while `cfg_load` = 1.
- `sel`  out  4  selection presented to the divisor; valid while `cfg_load` = 1.
- `cfg_load`  out  1  load request to the divisor.
- `leds`  out  4  committed value in IDLE/LOAD, candidate value in EDIT.
- `busy`  out  1  1 while in LOAD.
- `err`  out  1  sticky flag: last load timed out.

## Operation

- **Press detection:** press = level & ~previous level, one register per button. One press per rising input edge.
- **States:** IDLE, EDIT, LOAD. Internal registers are `cand` (candidate) and `comm` (committed), both 4 bits.
- **IDLE:**
  - up press → `cand` = `comm`+1, go to EDIT.
  - down press → `cand` = `comm`−1, go to EDIT.
  - ok press → `cand` = `comm`, go to LOAD (re-apply the current setting).
- **EDIT:**
  - up press → `cand`+1.
  - down press → `cand`−1.
  - ok press → go to LOAD.
- **Arithmetic wraps within [`MIN_SEL`, `MAX_SEL`]:**
  - `MAX_SEL`+1 → `MIN_SEL`.
  - `MIN_SEL`−1 → `MAX_SEL`.
  - Values outside this range never appear on `sel` or `leds`.
- **Simultaneous presses:**
  - up and down in the same cycle → both ignored.
  - ok together with up or down → ok wins, and the step is not applied.
- **LOAD:**
  - `cfg_load` = 1 and `sel` = `cand`, held stable until the cycle `cfg_ack` is sampled 1.
  - On ack: `comm` = `cand`, `err` = 0, go to IDLE.
  - If ack does not arrive within `ACK_TIMEOUT` cycles: `err` = 1, `comm` is unchanged, go to IDLE.
  - All button presses are ignored in LOAD; edge history keeps updating.
- **Reset values** (reset is valid in any state, including mid-LOAD; `cfg_load` drops in the next cycle):
  - state IDLE
  - `comm` = `cand` = `MIN_SEL`
  - `sel` = `MIN_SEL`, `leds` = `MIN_SEL`
  - `cfg_load` = 0, `busy` = 0, `err` = 0
  - edge registers = 0, so a button held through reset does not produce a press after reset.

## Timing

- A press whose level is first sampled high at edge k takes effect at edge k. The new state, `cand` and `leds` are visible after edge k.
- **Entering LOAD:** `cfg_load`, `busy` and `sel` are high/valid from the edge that takes the ok press.
- **Ack:**
  - `cfg_ack` sampled high at edge m updates `comm` at edge m.
  - `cfg_load` and `busy` are low after edge m.
  - `leds` shows the new `comm` after edge m.
- **Ack latency:** 0 is allowed, i.e. ack is accepted in the first LOAD cycle.
- **Timeout:**
  - The counter starts at 0 on LOAD entry.
  - Abort happens at the `ACK_TIMEOUT`-th LOAD cycle without ack.
  - Ack in that same cycle wins over the timeout.
- `cfg_ack` outside LOAD is ignored.

## Configuration

- **`DIVCTL_AUTOREPEAT_EN` defined:**
  - In EDIT, holding up (or down) alone generates extra steps.
  - The first extra step comes `REPEAT_DELAY` cycles after the press cycle; further steps follow every `REPEAT_RATE` cycles while held.
  - Releasing the button, pressing the other direction, or pressing ok resets the repeat counter.
  - There is no repeat in IDLE or LOAD.
- **`DIVCTL_AUTOREPEAT_EN` not defined:**
  - Only edges step the value; holding a button produces exactly one step.
  - The repeat counter logic is not synthesized.

## Test plan

- **Reset:** assert `rst` 1 cycle → `leds`=1, `cfg_load`=0, `busy`=0, `err`=0. Then hold `up` through reset release → no step.
- **Edit and wrap:**
  - From IDLE, 1 up press → EDIT, `leds`=2.
  - 14 more up presses → `leds`=1 (wrapped from 15).
  - 1 down press → `leds`=15.
- **Commit:** `cand`=6, ok, `cfg_ack` after 3 cycles → `cfg_load` high 4 cycles with `sel`=6, then IDLE, `leds`=6, `busy`=0.
- **Timeout:** `cand`=9, ok, `cfg_ack` never asserted → after 15 LOAD cycles `err`=1, `leds`=6. A subsequent acked load clears `err`.
- **Conflicts:**
  - up+down in the same cycle → no change.
  - ok+up in the same cycle in EDIT → LOAD with the unstepped `cand`.
  - Presses during LOAD → ignored.
  - `rst` mid-LOAD → IDLE, `leds`=1.
- **Auto-repeat** (`DIVCTL_AUTOREPEAT_EN`): in EDIT at 3, hold up for 20 cycles → steps at cycles 0, 8, 12, 16, giving `leds`=7. Without the macro → `leds`=4.
